lm75_poll_sched: RTL and testbench

- Autonomous scheduler that sequences a byte-level I2C master to poll an LM75 temperature register periodically.
- Converts the two-byte reading to a signed 9-bit temperature and drives an over-temperature flag with hysteresis.
- Retries NACKed transactions and counts errors.
- Sits between the system (enable, alarm, temperature) and the shared I2C master command port.

---
 rtl/lm75_poll_sched_if.sv | 21 ++
 rtl/lm75_poll_sched.sv | 216 +++++++++++++++++++++
 tb/tb_lm75_poll_sched.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lm75_poll_sched_if.sv
// Command/response port between the LM75 poll scheduler and a byte-level I2C master.
interface lm75_poll_sched_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic       cmd_nack;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_nack;

  modport master (
    output cmd_valid, cmd_op, cmd_nack, cmd_wdata,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_nack
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_nack, cmd_wdata,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_nack
  );
endinterface

// File: rtl/lm75_poll_sched.sv
// Periodic LM75 temperature poller driving a byte-level I2C master, with retry and hysteretic alarm.
// Define LM75_CFG_INIT_EN to write CFG_BYTE to the LM75 config register once after reset.
module lm75_poll_sched #(
  parameter int unsigned       POLL_CYCLES = 50000000,
  parameter logic [6:0]        DEV_ADDR    = 7'h48,
  parameter logic signed [8:0] T_HIGH      = 9'sd160,
  parameter logic signed [8:0] T_LOW       = 9'sd150,
  parameter int unsigned       MAX_RETRY   = 3,
  parameter logic [7:0]        CFG_BYTE    = 8'h00
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               enable_i,
  input  logic               poll_now_i,
  lm75_poll_sched_if.master  bus,
  output logic signed [8:0]  temp_o,
  output logic               temp_valid_o,
  output logic               over_temp_o,
  output logic               err_o,
  output logic [7:0]         err_cnt_o,
  output logic               busy_o
);

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;
  localparam logic [1:0] OP_STOP  = 2'b11;

  localparam int TW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(POLL_CYCLES - 1);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [7:0] WR_ADDR = {DEV_ADDR, 1'b0};
  localparam logic [7:0] RD_ADDR = {DEV_ADDR, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_RSP, S_PUBLISH, S_ABORT, S_ABORT_WAIT
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                pend_q, pend_d;
  logic [RW-1:0]       retry_q, retry_d;
  logic [7:0]          msb_q, msb_d;
  logic                lsb7_q, lsb7_d;
  logic signed [8:0]   temp_q, temp_d, new_temp;
  logic                temp_valid_q, temp_valid_d;
  logic                over_q, over_d;
  logic                err_q, err_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                cfg_done_q, cfg_done_d;
  logic                cfg_mode, req;
  logic [1:0]          step_op;
  logic [7:0]          step_wd;
  logic                step_nk;
  logic [2:0]          last_step;

`ifdef LM75_CFG_INIT_EN
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cfg_done_q <= 1'b0;
    else         cfg_done_q <= cfg_done_d;
`else
  logic unused_cfg;
  assign cfg_done_q = 1'b1;
  assign unused_cfg = cfg_done_d;
`endif

  assign cfg_mode = !cfg_done_q;
  assign req      = (enable_i && timer_q == '0) || poll_now_i;
  assign new_temp = {msb_q, lsb7_q};

  // Step index selects the command; config and poll transactions share the index.
  always_comb begin
    step_op   = OP_STOP;
    step_wd   = 8'h00;
    step_nk   = 1'b0;
    last_step = cfg_mode ? 3'd4 : 3'd7;
    if (cfg_mode) begin
      case (step_q)
        3'd0: step_op = OP_START;
        3'd1: begin step_op = OP_WRITE; step_wd = WR_ADDR;  end
        3'd2: begin step_op = OP_WRITE; step_wd = 8'h01;    end
        3'd3: begin step_op = OP_WRITE; step_wd = CFG_BYTE; end
        default: ;
      endcase
    end else begin
      case (step_q)
        3'd0: step_op = OP_START;
        3'd1: begin step_op = OP_WRITE; step_wd = WR_ADDR; end
        3'd2: begin step_op = OP_WRITE; step_wd = 8'h00;   end
        3'd3: step_op = OP_START;
        3'd4: begin step_op = OP_WRITE; step_wd = RD_ADDR; end
        3'd5: step_op = OP_READ;
        3'd6: begin step_op = OP_READ; step_nk = 1'b1; end
        default: ;
      endcase
    end
  end

  assign bus.cmd_valid = (state_q == S_ISSUE) || (state_q == S_ABORT);
  assign bus.cmd_op    = (state_q == S_ISSUE) ? step_op :
                         (state_q == S_ABORT) ? OP_STOP : OP_START;
  assign bus.cmd_wdata = (state_q == S_ISSUE) ? step_wd : 8'h00;
  assign bus.cmd_nack  = (state_q == S_ISSUE) ? step_nk : 1'b0;

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    timer_d      = timer_q;
    pend_d       = pend_q;
    retry_d      = retry_q;
    msb_d        = msb_q;
    lsb7_d       = lsb7_q;
    temp_d       = temp_q;
    temp_valid_d = 1'b0;
    over_d       = over_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    cfg_done_d   = cfg_done_q;

    if (enable_i && timer_q != '0) timer_d = timer_q - 1'b1;
    if (state_q != S_IDLE && req)  pend_d  = 1'b1;

    case (state_q)
      S_IDLE: if (req || pend_q) begin
        state_d = S_ISSUE;
        step_d  = 3'd0;
        pend_d  = 1'b0;
        timer_d = RELOAD;
      end
      S_ISSUE: if (bus.cmd_ready) state_d = S_WAIT_RSP;
      S_WAIT_RSP: if (bus.rsp_valid) begin
        if (step_op == OP_WRITE && bus.rsp_nack) begin
          state_d = S_ABORT;
          if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
        end else if (step_q == last_step) begin
          retry_d = '0;
          err_d   = 1'b0;
          if (cfg_mode) begin
            // Config done: queue the first poll right behind it.
            state_d    = S_IDLE;
            cfg_done_d = 1'b1;
            pend_d     = 1'b1;
          end else begin
            state_d      = S_PUBLISH;
            temp_d       = new_temp;
            temp_valid_d = 1'b1;
            if (new_temp >= T_HIGH)    over_d = 1'b1;
            else if (new_temp < T_LOW) over_d = 1'b0;
          end
        end else begin
          if (!cfg_mode && step_q == 3'd5) msb_d  = bus.rsp_rdata;
          if (!cfg_mode && step_q == 3'd6) lsb7_d = bus.rsp_rdata[7];
          step_d  = step_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_PUBLISH: state_d = S_IDLE;
      S_ABORT: if (bus.cmd_ready) state_d = S_ABORT_WAIT;
      S_ABORT_WAIT: if (bus.rsp_valid) begin
        if (retry_q < RW'(MAX_RETRY)) begin
          retry_d = retry_q + RW'(1);
          step_d  = 3'd0;
          state_d = S_ISSUE;
        end else begin
          retry_d = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
          if (cfg_mode) begin
            cfg_done_d = 1'b1;
            pend_d     = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      step_q       <= '0;
      timer_q      <= '0;
      pend_q       <= 1'b0;
      retry_q      <= '0;
      msb_q        <= '0;
      lsb7_q       <= 1'b0;
      temp_q       <= '0;
      temp_valid_q <= 1'b0;
      over_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      timer_q      <= timer_d;
      pend_q       <= pend_d;
      retry_q      <= retry_d;
      msb_q        <= msb_d;
      lsb7_q       <= lsb7_d;
      temp_q       <= temp_d;
      temp_valid_q <= temp_valid_d;
      over_q       <= over_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign temp_o       = temp_q;
  assign temp_valid_o = temp_valid_q;
  assign over_temp_o  = over_q;
  assign err_o        = err_q;
  assign err_cnt_o    = cnt_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_lm75_poll_sched.sv
// Scoreboard bench for lm75_poll_sched: an I2C-master responder checks every command and a monitor checks each publish.
module tb_lm75_poll_sched;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, poll_now = 1'b0;
  always #5 clk = ~clk;

  lm75_poll_sched_if bus();
  logic signed [8:0] temp;
  logic tv, ot, err, busy;
  logic [7:0] err_cnt;

  lm75_poll_sched #(.POLL_CYCLES(1000)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .poll_now_i(poll_now),
    .bus(bus), .temp_o(temp), .temp_valid_o(tv), .over_temp_o(ot),
    .err_o(err), .err_cnt_o(err_cnt), .busy_o(busy)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, last_rsp = 0, tv_cnt = 0, nack_left = 0;
  bit ready_en = 1'b1;
  logic [10:0] exp_cmd[$];
  logic [7:0]  rd_q[$];
  logic [10:0] exp_tv[$];
  int          rises[$];

  logic [7:0] t_msb[6] = '{8'h19, 8'hE7, 8'h50, 8'h4B, 8'h4A, 8'h4F};
  logic [7:0] t_lsb[6] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80};
  logic [8:0] t_tmp[6] = '{9'h033, 9'h1CE, 9'h0A0, 9'h096, 9'h095, 9'h09F};
  logic       t_ot[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic nk, input logic [7:0] wd);
    exp_cmd.push_back({op, nk, wd});
  endtask

  task automatic push_poll(input logic [7:0] msb, input logic [7:0] lsb,
                           input logic [8:0] t, input logic o);
    push_cmd(2'b00, 1'b0, 8'h00); push_cmd(2'b01, 1'b0, 8'h90);
    push_cmd(2'b01, 1'b0, 8'h00); push_cmd(2'b00, 1'b0, 8'h00);
    push_cmd(2'b01, 1'b0, 8'h91); push_cmd(2'b10, 1'b0, 8'h00);
    push_cmd(2'b10, 1'b1, 8'h00); push_cmd(2'b11, 1'b0, 8'h00);
    rd_q.push_back(msb); rd_q.push_back(lsb);
    exp_tv.push_back({1'b0, o, t});
  endtask

  task automatic pulse_poll();
    @(negedge clk); poll_now = 1'b1;
    @(negedge clk); poll_now = 1'b0;
  endtask

  task automatic wait_quiet(input int bound, input string tag);
    int q = 0, n = 0;
    while (q < 5 && n < bound) begin
      @(negedge clk); n++;
      if (busy) q = 0; else q++;
    end
    chk(tag, 32'(n < bound), 1);
  endtask

  // Responder: accepts each offered command, answers 3 cycles later.
  initial begin : resp
    int cnt = -1;
    logic [1:0] pop = 2'b00;
    logic [7:0] pwd = 8'h00;
    logic [10:0] e;
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = 8'h00; bus.rsp_nack = 1'b0;
    forever begin
      @(negedge clk);
      bus.rsp_valid = 1'b0; bus.rsp_nack = 1'b0; bus.rsp_rdata = 8'h00;
      if (!rst_n) cnt = -1;
      else begin
        if (cnt == 0) begin
          bus.rsp_valid = 1'b1;
          last_rsp = cyc;
          if (pop == 2'b10 && rd_q.size() > 0) bus.rsp_rdata = rd_q.pop_front();
          if (pop == 2'b01 && pwd == 8'h90 && nack_left > 0) begin
            bus.rsp_nack = 1'b1; nack_left--;
          end
        end
        if (cnt >= 0) cnt--;
      end
      bus.cmd_ready = ready_en;
      if (rst_n && bus.cmd_valid && bus.cmd_ready) begin
        pop = bus.cmd_op; pwd = bus.cmd_wdata;
        e = (exp_cmd.size() > 0) ? exp_cmd.pop_front() : 11'h7FF;
        chk("cmd", {bus.cmd_op, bus.cmd_nack, bus.cmd_wdata}, e);
        cnt = 2;
      end
    end
  end

  initial begin : mon
    logic pb = 1'b0;
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (busy && !pb) rises.push_back(cyc);
      pb = busy;
      if (tv) begin
        tv_cnt++;
        e = (exp_tv.size() > 0) ? exp_tv.pop_front() : 11'h7FF;
        chk("publish", {1'b0, ot, temp}, e);
        chk("tv_lat", cyc - last_rsp, 1);
      end
    end
  end

  initial begin : main
    int b, n, chg, t0, r0, r1, r2;
    logic [11:0] smp;
    repeat (3) @(negedge clk);
    chk("rst_outs", {temp, tv, ot, err, err_cnt, busy, bus.cmd_valid}, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Periodic polling from the timer
    rises.delete();
    for (int i = 0; i < 3; i++) push_poll(8'h19, 8'h80, 9'h033, 1'b0);
    b = tv_cnt; n = 0;
    enable = 1'b1; t0 = cyc;
    while (tv_cnt < b + 3 && n < 4000) begin @(negedge clk); n++; end
    enable = 1'b0;
    chk("tick_tv", tv_cnt - b, 3);
    wait_quiet(200, "tick_quiet");
    r0 = (rises.size() > 0) ? rises[0] : -5000;
    r1 = (rises.size() > 1) ? rises[1] : -5000;
    r2 = (rises.size() > 2) ? rises[2] : -5000;
    chk("first_start", r0 - t0, 1);
    chk("period1", r1 - r0, 1000);
    chk("period2", r2 - r1, 1000);

    // Conversion and hysteresis table
    for (int i = 0; i < 6; i++) begin
      push_poll(t_msb[i], t_lsb[i], t_tmp[i], t_ot[i]);
      b = tv_cnt;
      pulse_poll();
      wait_quiet(400, "tbl_quiet");
      chk("tbl_tv", tv_cnt - b, 1);
      chk("tbl_left", exp_cmd.size(), 0);
    end

    // NACK on the address byte every attempt
    nack_left = 4;
    for (int i = 0; i < 4; i++) begin
      push_cmd(2'b00, 1'b0, 8'h00); push_cmd(2'b01, 1'b0, 8'h90); push_cmd(2'b11, 1'b0, 8'h00);
    end
    b = tv_cnt;
    pulse_poll();
    wait_quiet(600, "nack_quiet");
    chk("nack_err", err, 1);
    chk("nack_cnt", err_cnt, 4);
    chk("nack_temp", temp, 9'h09F);
    chk("nack_tv", tv_cnt - b, 0);
    chk("nack_left", exp_cmd.size(), 0);

    push_poll(8'h19, 8'h80, 9'h033, 1'b0);
    pulse_poll();
    wait_quiet(400, "clean_quiet");
    chk("clean_err", err, 0);
    chk("clean_cnt", err_cnt, 4);

    // Two poll_now requests mid-transaction collapse into one extra poll
    push_poll(8'hE7, 8'h00, 9'h1CE, 1'b0);
    push_poll(8'h19, 8'h80, 9'h033, 1'b0);
    b = tv_cnt;
    pulse_poll();
    repeat (6) @(negedge clk);
    pulse_poll();
    repeat (4) @(negedge clk);
    pulse_poll();
    wait_quiet(800, "dbl_quiet");
    chk("dbl_tv", tv_cnt - b, 2);
    chk("dbl_left", exp_cmd.size(), 0);

    // Command held stable while the master stalls
    ready_en = 1'b0;
    push_poll(8'h19, 8'h80, 9'h033, 1'b0);
    pulse_poll();
    smp = {bus.cmd_valid, bus.cmd_op, bus.cmd_nack, bus.cmd_wdata};
    chg = 0;
    repeat (50) begin
      @(negedge clk);
      if ({bus.cmd_valid, bus.cmd_op, bus.cmd_nack, bus.cmd_wdata} !== smp) chg++;
    end
    chk("hold_chg", chg, 0);
    chk("hold_valid", bus.cmd_valid, 1);
    ready_en = 1'b1;
    wait_quiet(400, "hold_quiet");

    // Asynchronous reset during a READ
    push_poll(8'h19, 8'h80, 9'h033, 1'b0);
    pulse_poll();
    n = 0;
    while (!(bus.cmd_valid && bus.cmd_op == 2'b10) && n < 400) begin @(negedge clk); n++; end
    chk("rd_seen", 32'(n < 400), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid", {temp, tv, ot, err, err_cnt, busy, bus.cmd_valid}, 0);
    repeat (3) @(negedge clk);
    exp_cmd.delete(); rd_q.delete(); exp_tv.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
